// File: rtl/gpr_wb_arb.sv
// Register-file write-port arbiter: pipeline W-stage writes win, multi-cycle results queue in a FIFO and drain into idle cycles.
// Optional starvation guard (stall_req generation) enabled by defining WB_STARVE_GUARD_EN.
module gpr_wb_arb #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_we,
    input  logic [4:0]  p_a,
    input  logic [31:0] p_wd,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_a,
    input  logic [31:0] m_wd,
    output logic        we,
    output logic [4:0]  a3,
    output logic [31:0] wd,
    output logic        empty,
    output logic        stall_req
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("gpr_wb_arb: DEPTH must be a power of two in 2..16");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("gpr_wb_arb: STARVE_LIMIT must fit the 4-bit starvation counter");
    end

    logic [4:0]       a_mem  [DEPTH];
    logic [31:0]      wd_mem [DEPTH];
    logic [DEPTH-1:0] live_reg, live_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic p_eff;
    logic accept;
    logic push;
    logic pop;
    logic head_live;

    assign p_eff   = p_we && (p_a != 5'd0);
    assign m_ready = (count_reg < DEPTH_C) && !reset;
    assign accept  = m_valid && m_ready;
    // Accepted results aimed at r0, or overtaken in the same cycle by a pipeline write, are dropped.
    assign push    = accept && (m_a != 5'd0) && !(p_eff && (m_a == p_a));
    assign pop     = !reset && !p_eff && (count_reg != '0);
    assign head_live = live_reg[rd_ptr_reg];
    assign empty   = (count_reg == '0);

    always_comb begin
        we = 1'b0;
        a3 = 5'd0;
        wd = 32'd0;
        if (!reset) begin
            if (p_eff) begin
                we = 1'b1;
                a3 = p_a;
                wd = p_wd;
            end else if (pop && head_live) begin
                we = 1'b1;
                a3 = a_mem[rd_ptr_reg];
                wd = wd_mem[rd_ptr_reg];
            end
        end
    end

    // A pipeline write squashes every older buffered write to the same register.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic is_push_slot;
        logic is_pop_slot;
        logic is_squashed;
        assign is_push_slot = push && (wr_ptr_reg == PTR_W'(gi));
        assign is_pop_slot  = pop && (rd_ptr_reg == PTR_W'(gi));
        assign is_squashed  = p_eff && (a_mem[gi] == p_a);
        assign live_next[gi] = is_push_slot || (live_reg[gi] && !is_pop_slot && !is_squashed);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr_reg]  <= m_a;
            wd_mem[wr_ptr_reg] <= m_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            live_reg <= live_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_reg, starve_cnt_next;
    logic       stall_reg, stall_next;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (pop)
            starve_cnt_next = 4'd0;
        else if ((count_reg != '0) && p_eff && (starve_cnt_reg != 4'hF))
            starve_cnt_next = starve_cnt_reg + 4'd1;
        // Stall holds until the queue actually drains an entry, even if the pipeline ignores it.
        stall_next = pop ? 1'b0 : (stall_reg || (starve_cnt_next >= LIMIT_C));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_reg <= 4'd0;
            stall_reg      <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            stall_reg      <= stall_next;
        end
    end

    assign stall_req = stall_reg;
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Directed testbench for gpr_wb_arb; starvation scenario is exercised when WB_STARVE_GUARD_EN is defined.
module tb_gpr_wb_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_we;
    logic [4:0]  p_a;
    logic [31:0] p_wd;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_a;
    logic [31:0] m_wd;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        empty;
    logic        stall_req;

    int checks = 0;
    int errors = 0;
    logic [31:0] rf [32];

    gpr_wb_arb #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .p_we(p_we), .p_a(p_a), .p_wd(p_wd),
        .m_valid(m_valid), .m_ready(m_ready), .m_a(m_a), .m_wd(m_wd),
        .we(we), .a3(a3), .wd(wd), .empty(empty), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    // Register-file shadow plus one log line per write / accepted handshake.
    always @(negedge clk) begin
        if (we) begin
            rf[a3] = wd;
            $display("%0t write a3=%0d wd=%08h", $time, a3, wd);
        end
        if (m_valid && m_ready)
            $display("%0t accept m_a=%0d m_wd=%08h", $time, m_a, m_wd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_we = 1'b0; p_a = 5'd0; p_wd = 32'd0;
        m_valid = 1'b0; m_a = 5'd0; m_wd = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_m_ready got %b want 0", m_ready); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (we !== 1'b0 || a3 !== 5'd0 || wd !== 32'd0) begin errors++; $display("FAIL reset_port got we=%b a3=%0d wd=%h want 0/0/0", we, a3, wd); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_req); end
        reset = 1'b0;
        #1;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL post_reset_m_ready got %b want 1", m_ready); end
    endtask

    task automatic test_single();
        m_valid = 1'b1; m_a = 5'd5; m_wd = 32'hDEADBEEF;
        #1;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL single_m_ready got %b want 1", m_ready); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL single_no_passthru got we=%b want 0", we); end
        tick();
        m_valid = 1'b0;
        #1;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", empty); end
        checks++; if (we !== 1'b1 || a3 !== 5'd5 || wd !== 32'hDEADBEEF) begin errors++; $display("FAIL single_drain got we=%b a3=%0d wd=%h want 1/5/deadbeef", we, a3, wd); end
        tick();
        checks++; if (empty !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL single_after got empty=%b we=%b want 1/0", empty, we); end
    endtask

    task automatic test_fill();
        p_we = 1'b1; p_a = 5'd7;
        for (int i = 0; i < 4; i++) begin
            p_wd = 32'h700 + i;
            m_valid = 1'b1; m_a = 5'(10 + i); m_wd = 32'h100 + i;
            #1;
            checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %b want 1", i, m_ready); end
            checks++; if (we !== 1'b1 || a3 !== 5'd7 || wd !== 32'h700 + i) begin errors++; $display("FAIL fill_pipe[%0d] got we=%b a3=%0d wd=%h want 1/7/%h", i, we, a3, wd, 32'h700 + i); end
            tick();
        end
        m_a = 5'd30; m_wd = 32'hBAD;
        #1;
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b want 0", m_ready); end
        checks++; if (we !== 1'b1 || a3 !== 5'd7) begin errors++; $display("FAIL fill_full_pipe got we=%b a3=%0d want 1/7", we, a3); end
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (we !== 1'b1 || a3 !== 5'(10 + i) || wd !== 32'h100 + i) begin errors++; $display("FAIL fill_drain[%0d] got we=%b a3=%0d wd=%h want 1/%0d/%h", i, we, a3, wd, 10 + i, 32'h100 + i); end
            tick();
        end
        checks++; if (empty !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL fill_done got empty=%b we=%b want 1/0", empty, we); end
        checks++; if (rf[30] !== 32'd0) begin errors++; $display("FAIL fill_no_overflow got rf30=%h want 0", rf[30]); end
    endtask

    task automatic test_squash();
        p_we = 1'b1; p_a = 5'd7; p_wd = 32'h77;
        m_valid = 1'b1; m_a = 5'd9; m_wd = 32'h1;
        tick();
        m_valid = 1'b0;
        p_a = 5'd9; p_wd = 32'h2;
        #1;
        checks++; if (we !== 1'b1 || a3 !== 5'd9 || wd !== 32'h2) begin errors++; $display("FAIL squash_pipe got we=%b a3=%0d wd=%h want 1/9/2", we, a3, wd); end
        tick();
        idle_inputs();
        #1;
        checks++; if (empty !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL squash_pop got empty=%b we=%b want 0/0", empty, we); end
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL squash_empty got %b want 1", empty); end
        checks++; if (rf[9] !== 32'h2) begin errors++; $display("FAIL squash_last_r9 got %h want 2", rf[9]); end
    endtask

    task automatic test_same_cycle_drop();
        p_we = 1'b1; p_a = 5'd3; p_wd = 32'h30;
        m_valid = 1'b1; m_a = 5'd3; m_wd = 32'h33;
        #1;
        checks++; if (m_ready !== 1'b1 || we !== 1'b1 || a3 !== 5'd3 || wd !== 32'h30) begin errors++; $display("FAIL same_addr got rdy=%b we=%b a3=%0d wd=%h want 1/1/3/30", m_ready, we, a3, wd); end
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL same_addr_empty got %b want 1", empty); end
        p_we = 1'b0; p_a = 5'd0;
        m_a = 5'd0; m_wd = 32'h55;
        #1;
        checks++; if (m_ready !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL r0_accept got rdy=%b we=%b want 1/0", m_ready, we); end
        tick();
        m_valid = 1'b0;
        p_we = 1'b1; p_a = 5'd0; p_wd = 32'h66;
        #1;
        checks++; if (empty !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL r0_drop got empty=%b we=%b want 1/0", empty, we); end
        tick();
        idle_inputs();
        checks++; if (rf[3] !== 32'h30) begin errors++; $display("FAIL same_addr_r3 got %h want 30", rf[3]); end
    endtask

    task automatic test_starve();
        p_we = 1'b1; p_a = 5'd4; p_wd = 32'h44;
        m_valid = 1'b1; m_a = 5'd10; m_wd = 32'hAA;
        tick();
        m_valid = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        for (int k = 1; k <= 8; k++) begin
            checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_early[%0d] got %b want 0", k, stall_req); end
            tick();
        end
        checks++; if (stall_req !== 1'b1 || we !== 1'b1 || a3 !== 5'd4) begin errors++; $display("FAIL starve_raise got stall=%b we=%b a3=%0d want 1/1/4", stall_req, we, a3); end
        tick();
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_hold got %b want 1", stall_req); end
        p_we = 1'b0;
        #1;
        checks++; if (we !== 1'b1 || a3 !== 5'd10 || wd !== 32'hAA) begin errors++; $display("FAIL starve_drain got we=%b a3=%0d wd=%h want 1/10/aa", we, a3, wd); end
        tick();
        checks++; if (stall_req !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL starve_clear got stall=%b empty=%b want 0/1", stall_req, empty); end
`else
        for (int k = 1; k <= 10; k++) tick();
        checks++; if (stall_req !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL noguard_stall got stall=%b empty=%b want 0/0", stall_req, empty); end
        p_we = 1'b0;
        #1;
        checks++; if (we !== 1'b1 || a3 !== 5'd10 || wd !== 32'hAA) begin errors++; $display("FAIL noguard_drain got we=%b a3=%0d wd=%h want 1/10/aa", we, a3, wd); end
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL noguard_empty got %b want 1", empty); end
`endif
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        p_we = 1'b1; p_a = 5'd7; p_wd = 32'h7;
        for (int i = 0; i < 3; i++) begin
            m_valid = 1'b1; m_a = 5'(20 + i); m_wd = 32'h200 + i;
            tick();
        end
        reset = 1'b1;
        p_we = 1'b0; p_a = 5'd0;
        m_a = 5'd23; m_wd = 32'h203;
        #1;
        checks++; if (m_ready !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL midreset_in got rdy=%b we=%b want 0/0", m_ready, we); end
        tick();
        reset = 1'b0;
        m_valid = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL midreset_out got empty=%b we=%b want 1/0", empty, we); end
        for (int i = 0; i < 3; i++) tick();
        for (int i = 20; i < 24; i++) begin
            checks++; if (rf[i] !== 32'd0) begin errors++; $display("FAIL midreset_rf[%0d] got %h want 0", i, rf[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        test_reset();
        test_single();
        test_fill();
        test_squash();
        test_same_cycle_drop();
        test_starve();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arb.md
# gpr_wb_arb

Write-side arbiter for the general-purpose register file's single write port. Merges the in-order pipeline's W-stage result, which has absolute priority and no backpressure, with results from the multi-cycle unit (loads/mul/div), which arrive over a valid/ready handshake. Multi-cycle results are buffered in a small FIFO and drained into idle write-port cycles. Program order is preserved by squashing buffered results that a newer pipeline write overtakes. Sits between the W stage / multi-cycle unit and the register file's `we`/`a3`/`wd` inputs.

## Interface
- `DEPTH`, 4, FIFO entries (power of two, 2..16)
- `STARVE_LIMIT`, 8, consecutive blocked drain cycles before a stall request (guard build only)
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `p_we`  in  1  pipeline write request this cycle
- `p_a`  in  5  pipeline destination register
- `p_wd`  in  32  pipeline write data
- `m_valid`  in  1  multi-cycle result valid
- `m_ready`  out  1  arbiter can accept a multi-cycle result
- `m_a`  in  5  multi-cycle destination register
- `m_wd`  in  32  multi-cycle write data
- `we`  out  1  register-file write enable
- `a3`  out  5  register-file write address
- `wd`  out  32  register-file write data
- `empty`  out  1  FIFO holds no entries (valid or squashed)
- `stall_req`  out  1  request that the pipeline suppress `p_we` for one cycle

## Operation
- Pipeline write is effective when `p_we` is 1 and `p_a` is not 0.
- FIFO entry fields: `a` (5 bits), `wd` (32 bits), live bit. `count` ranges 0..DEPTH. Pointers wrap modulo DEPTH.
- `m_ready` = (`count` < DEPTH) and not `reset`. There is no pop-through when full.
- Enqueue occurs on a cycle with `m_valid` and `m_ready`, with these exceptions:
  - `m_a` = 0: the result is accepted (handshake completes) but discarded, with no enqueue.
  - `m_a` equals `p_a` of an effective pipeline write in the same cycle: the result is accepted and discarded. The pipeline write is always program-order newer.
- Write-port select, combinational each cycle:
  - Effective pipeline write: `we`=1, `a3`=`p_a`, `wd`=`p_wd`. No pop.
  - Otherwise, if `count` > 0: pop the head. If the head is live, `we`=1, `a3`=head.a, `wd`=head.wd. If the head is squashed, `we`=0 and the entry is simply removed.
  - Otherwise: `we`=0. `a3` and `wd` are don't-care, driven as 0.
- Squash: an effective pipeline write clears the live bit of every FIFO entry whose `a` equals `p_a`, at that edge.
- A push and a pop in the same cycle leave `count` unchanged.
- Writes to register 0 never appear on `we`.
- `empty` = (`count` == 0).

## Timing
- Pipeline write: zero latency, combinational pass-through to `we`/`a3`/`wd`. It lands at the same edge the register file samples.
- Multi-cycle result accepted at edge N: earliest write-port appearance is cycle N+1 (registered FIFO). It is written at edge N+1.
- Drain rate is one entry per cycle in which no effective pipeline write is present.
- Reset values: `count`=0, all live bits 0, pointers 0, `empty`=1, `m_ready`=0 while `reset`=1 (1 in the first cycle after), `we`=0, `a3`=0, `wd`=0, `stall_req`=0, starvation counter 0.
- Reset mid-operation discards all buffered entries. Any handshake in progress in a reset cycle is not accepted.

## Configuration
- `WB_STARVE_GUARD_EN` defined:
  - A 4-bit saturating counter increments on each cycle with `count` > 0 and an effective pipeline write.
  - The counter clears on any pop.
  - When the counter reaches `STARVE_LIMIT`, `stall_req` (a register) is 1 in the next cycle and stays 1 until a pop occurs. It deasserts on the cycle after that pop.
  - Contract: the pipeline drives `p_we`=0 while `stall_req`=1. If it does not, the pipeline still wins and `stall_req` holds.
- Not defined: `stall_req` is tied to 0 and the counter is not built.

## Test plan
- Reset, then a single `m_valid` with `m_a`=5, `m_wd`=0xDEADBEEF, no pipeline traffic:
  - `m_ready`=1, `empty`=0 next cycle.
  - Next cycle: `we`=1, `a3`=5, `wd`=0xDEADBEEF.
  - `empty`=1 after that.
- Fill to DEPTH=4 while `p_we`=1 to reg 7 every cycle:
  - `m_ready`=0 after 4 accepts.
  - `we`/`a3` track the pipeline only (`a3`=7).
  - Drop `p_we`: 4 consecutive drains in FIFO order.
- Queue `m_a`=9 (0x1), then a pipeline write to reg 9 (0x2), then idle:
  - The reg-9 entry is squashed.
  - Its pop cycle shows `we`=0.
  - The last value written to reg 9 is 0x2.
- Simultaneous `m_valid` with `m_a`=3 and `p_we` with `p_a`=3; separately `m_a`=0:
  - Both handshakes complete.
  - Neither result is enqueued (`empty` stays 1).
- With `WB_STARVE_GUARD_EN`, STARVE_LIMIT=8, one entry queued and `p_we`=1 to reg 4 continuously:
  - `stall_req`=1 on the cycle after 8 blocked cycles.
  - Pipeline drops `p_we`: the entry drains.
  - `stall_req`=0 the following cycle.
- Assert `reset` with 3 entries queued:
  - Next cycle `empty`=1 and `we`=0.
  - No buffered entry is ever written.
